// File: rtl/gf2_poly_mod_reducer.sv
// Bit-serial GF(2)[x] long divider: dividend (2N bits) / (x^N + modpoly) -> quotient, remainder (N bits each).
// Latency N cycles (N/2 when GF2_DIV_DIGIT2_EN is defined); one transaction at a time, no backpressure.
module gf2_poly_mod_reducer #(
    parameter int N = 192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     modpoly,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     remainder,
    output logic [N-1:0]     quotient
);

    localparam int CW = $clog2(N + 1);
`ifdef GF2_DIV_DIGIT2_EN
    localparam logic [CW-1:0] STEP     = CW'(2);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 2);
`else
    localparam logic [CW-1:0] STEP     = CW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    r_q, r_d;
    logic [N-1:0]    s_q, s_d;
    logic [N-1:0]    pm_q;
    logic [N-1:0]    q_q, q_d;
    logic [CW-1:0]   cnt_q;
    logic [N-1:0]    rem_q;
    logic [N-1:0]    quo_q;

    logic            load;
    logic            finish;

    logic            qb1;
    logic [N-1:0]    r1, s1, q1;

    assign load   = start && ((state_q == IDLE) || (state_q == DONE));
    assign finish = (state_q == RUN) && (cnt_q == LAST_CNT);

    // One division step: shift the next dividend bit into R and cancel the x^N term with P.
    always_comb begin
        qb1 = r_q[N-1];
        r1  = {r_q[N-2:0], s_q[N-1]} ^ (pm_q & {N{qb1}});
        s1  = s_q << 1;
        q1  = {q_q[N-2:0], qb1};
    end

`ifdef GF2_DIV_DIGIT2_EN
    logic qb2;

    always_comb begin
        qb2 = r1[N-1];
        r_d = {r1[N-2:0], s1[N-1]} ^ (pm_q & {N{qb2}});
        s_d = s1 << 1;
        q_d = {q1[N-2:0], qb2};
    end
`else
    always_comb begin
        r_d = r1;
        s_d = s1;
        q_d = q1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (finish) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Operands are captured at start so input changes during RUN cannot disturb the division.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= '0;
            s_q   <= '0;
            pm_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (load) begin
            r_q   <= dividend[2*N-1:N];
            s_q   <= dividend[N-1:0];
            pm_q  <= modpoly;
            q_q   <= '0;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            r_q   <= r_d;
            s_q   <= s_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + STEP;
        end
    end

    // Result registers update only on the final step, so partial values are never visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (finish) begin
            rem_q <= r_d;
            quo_q <= q_d;
        end
    end

    assign remainder = rem_q;
    assign quotient  = quo_q;

endmodule

// File: tb/tb_gf2_poly_mod_reducer.sv
// Self-checking bench for gf2_poly_mod_reducer: directed table, random back-to-back traffic, mid-run start and reset.
module tb_gf2_poly_mod_reducer;

    localparam int N = 192;
`ifdef GF2_DIV_DIGIT2_EN
    localparam int LAT = N / 2;
`else
    localparam int LAT = N;
`endif
    localparam int NRAND = 200;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [2*N-1:0]   dividend = '0;
    logic [N-1:0]     modpoly = '0;
    logic             busy;
    logic             done;
    logic [N-1:0]     remainder;
    logic [N-1:0]     quotient;

    int tests = 0;
    int fails = 0;

    gf2_poly_mod_reducer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .modpoly   (modpoly),
        .busy      (busy),
        .done      (done),
        .remainder (remainder),
        .quotient  (quotient)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*N-1:0] a;
        logic [N-1:0]   pm;
        logic [N-1:0]   rem;
        logic [N-1:0]   quo;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Textbook GF(2) long division by the full modulus x^N + pm.
    function automatic void gf_div(input logic [2*N-1:0] a, input logic [N-1:0] pm,
                                   output logic [N-1:0] rem, output logic [N-1:0] quo);
        logic [2*N-1:0] work;
        logic [2*N-1:0] pfull;
        work  = a;
        pfull = {{(N-1){1'b0}}, 1'b1, pm};
        quo   = '0;
        for (int i = 2*N-1; i >= N; i--) begin
            if (work[i]) begin
                work       = work ^ (pfull << (i - N));
                quo[i - N] = 1'b1;
            end
        end
        rem = work[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_n();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Ticks until done is seen (or the budget runs out); cyc counts ticks after the start edge.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done && cyc < 2*N + 20);
    endtask

    task automatic launch(input logic [2*N-1:0] a, input logic [N-1:0] pm);
        dividend = a;
        modpoly  = pm;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        int cyc;
        int done_seen;
        logic [2*N-1:0] a, b;
        logic [N-1:0]   pm, pm2, erem, equo;

        vecs[0].a = '0;                vecs[0].pm = 192'h87; vecs[0].rem = '0;           vecs[0].quo = '0;
        vecs[1].a = 384'd1;            vecs[1].pm = 192'h87; vecs[1].rem = 192'd1;       vecs[1].quo = '0;
        vecs[2].a = 384'd1 << 192;     vecs[2].pm = 192'h87; vecs[2].rem = 192'h87;      vecs[2].quo = 192'd1;
        vecs[3].a = 384'd1 << 200;     vecs[3].pm = 192'h87; vecs[3].rem = 192'h8700;    vecs[3].quo = 192'h100;

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("reset_busy", N'(busy), '0);
        check("reset_done", N'(done), '0);
        check("reset_rem", remainder, '0);
        check("reset_quo", quotient, '0);

        for (int v = 0; v < 4; v++) begin
            launch(vecs[v].a, vecs[v].pm);
            check($sformatf("vec%0d_busy", v), N'(busy), N'(1));
            wait_done(cyc);
            check($sformatf("vec%0d_latency", v), N'(cyc), N'(LAT));
            check($sformatf("vec%0d_rem", v), remainder, vecs[v].rem);
            check($sformatf("vec%0d_quo", v), quotient, vecs[v].quo);
            tick();
            check($sformatf("vec%0d_done_pulse", v), N'(done), '0);
            tick();
            check($sformatf("vec%0d_rem_hold", v), remainder, vecs[v].rem);
        end

        // Random traffic, each new start issued in the DONE cycle of the previous one.
        a  = {rand_n(), rand_n()};
        pm = rand_n();
        gf_div(a, pm, erem, equo);
        launch(a, pm);
        for (int t = 0; t < NRAND; t++) begin
            dividend = {rand_n(), rand_n()};
            modpoly  = rand_n();
            wait_done(cyc);
            check($sformatf("rnd%0d_spacing", t), N'(cyc + 1), N'(LAT + 1));
            check($sformatf("rnd%0d_rem", t), remainder, erem);
            check($sformatf("rnd%0d_quo", t), quotient, equo);
            if (t < NRAND - 1) begin
                a  = {rand_n(), rand_n()};
                pm = rand_n();
                gf_div(a, pm, erem, equo);
                launch(a, pm);
            end
        end
        tick();
        check("rnd_done_drop", N'(done), '0);

        // A start pulse mid-run with new operands must not disturb the operation in flight.
        a   = {rand_n(), rand_n()} | (384'd1 << 383);
        pm  = rand_n();
        b   = {rand_n(), rand_n()};
        pm2 = rand_n();
        gf_div(a, pm, erem, equo);
        launch(a, pm);
        cyc = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            cyc++;
        end
        dividend = b;
        modpoly  = pm2;
        start    = 1'b1;
        tick();
        cyc++;
        start    = 1'b0;
        done_seen = cyc;
        wait_done(cyc);
        check("midrun_latency", N'(done_seen + cyc), N'(LAT));
        check("midrun_rem", remainder, erem);
        check("midrun_quo", quotient, equo);

        // Reset at cycle 50 of a run: outputs clear immediately and no done ever appears.
        launch({rand_n(), rand_n()}, rand_n());
        for (int c = 0; c < 49; c++) tick();
        rst = 1'b1;
        #1;
        check("rst_busy", N'(busy), '0);
        check("rst_done", N'(done), '0);
        check("rst_rem", remainder, '0);
        check("rst_quo", quotient, '0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < LAT + 10; c++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("rst_no_done", N'(done_seen), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
